// File: rtl/ub_pkg.sv
// Shared sizes, read-FSM state type and row alignment helper for the unified-buffer access controller.
package ub_pkg;

   localparam int SIZE             = 8;
   localparam int ACTIVATION_WIDTH = 7;
   localparam int ADDR_WIDTH       = 6;
   localparam int DEPTH            = 1 << ADDR_WIDTH;
   localparam int ROW_WIDTH        = SIZE * ACTIVATION_WIDTH;
   localparam int CNT_WIDTH        = $clog2(DEPTH) + 1;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rd_state_t;

   // Rows are SIZE entries wide, so a row base is the address with its in-row offset cleared.
   function automatic logic [ADDR_WIDTH-1:0] row_align(input logic [ADDR_WIDTH-1:0] addr);
      localparam logic [ADDR_WIDTH-1:0] ROW_MASK = ADDR_WIDTH'(SIZE - 1);
      return addr & ~ROW_MASK;
   endfunction

endpackage

// File: rtl/ub_wr_arbiter.sv
// Two-way round-robin arbiter for the UB write port; req/gnt bit 0 = host, bit 1 = accumulator.
module ub_wr_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       block,
   output logic [1:0] gnt
);

   logic favour_acc;

   always_comb begin
      gnt = 2'b00;
      if (!block) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = favour_acc ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Pointer only moves on an actual grant, so a blocked cycle leaves it untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         favour_acc <= 1'b1;
      end else if (gnt[0]) begin
         favour_acc <= 1'b1;
      end else if (gnt[1]) begin
         favour_acc <= 1'b0;
      end
   end

endmodule

// File: rtl/ub_access_ctrl.sv
// Unified-buffer port owner: arbitrated row writes plus a start/busy/done activation read stream.
// Define UB_RD_WR_INTERLOCK_EN to hold off all writes while a read stream is in progress.
module ub_access_ctrl
   import ub_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        host_wr_req,
   input  logic [ADDR_WIDTH-1:0]       host_wr_addr,
   input  logic [ROW_WIDTH-1:0]        host_wr_data,
   output logic                        host_wr_gnt,
   input  logic                        acc_wr_req,
   input  logic [ADDR_WIDTH-1:0]       acc_wr_addr,
   input  logic [ROW_WIDTH-1:0]        acc_wr_data,
   output logic                        acc_wr_gnt,
   output logic                        ub_wr_en,
   output logic [ADDR_WIDTH-1:0]       ub_wr_addr,
   output logic [ROW_WIDTH-1:0]        ub_wr_data,
   input  logic                        rd_start,
   input  logic [ADDR_WIDTH-1:0]       rd_base,
   input  logic [ADDR_WIDTH:0]         rd_len,
   output logic                        rd_busy,
   output logic [ADDR_WIDTH-1:0]       ub_rd_addr,
   input  logic [ACTIVATION_WIDTH-1:0] ub_rd_data,
   output logic                        rd_valid,
   output logic [ACTIVATION_WIDTH-1:0] rd_data,
   output logic                        rd_done
);

   // state  | meaning
   // IDLE   | no stream; rd_start sampled, rd_len==0 gives an immediate done pulse
   // STREAM | one UB address issued and one entry captured per cycle until cnt runs out

   rd_state_t            state, state_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [1:0]           gnt;
   logic                 wr_block;

`ifdef UB_RD_WR_INTERLOCK_EN
   assign wr_block = rd_busy;
`else
   assign wr_block = 1'b0;
`endif

   ub_wr_arbiter u_wr_arbiter (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({acc_wr_req, host_wr_req}),
      .block (wr_block),
      .gnt   (gnt)
   );

   assign host_wr_gnt = gnt[0];
   assign acc_wr_gnt  = gnt[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ub_wr_en   <= 1'b0;
         ub_wr_addr <= '0;
         ub_wr_data <= '0;
      end else if (host_wr_gnt) begin
         ub_wr_en   <= 1'b1;
         ub_wr_addr <= row_align(host_wr_addr);
         ub_wr_data <= host_wr_data;
      end else if (acc_wr_gnt) begin
         ub_wr_en   <= 1'b1;
         ub_wr_addr <= row_align(acc_wr_addr);
         ub_wr_data <= acc_wr_data;
      end else begin
         ub_wr_en   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (rd_start && (rd_len != '0)) state_nxt = STREAM;
         STREAM:  if (cnt == CNT_WIDTH'(1))       state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_busy = (state == STREAM);

   // rd_done is registered alongside the final capture, so it lines up with the last rd_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ub_rd_addr <= '0;
         cnt        <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         rd_done    <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         rd_done  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (rd_start) begin
                  if (rd_len == '0) begin
                     rd_done <= 1'b1;
                  end else begin
                     ub_rd_addr <= rd_base;
                     cnt        <= rd_len;
                  end
               end
            end
            STREAM: begin
               rd_data    <= ub_rd_data;
               rd_valid   <= 1'b1;
               ub_rd_addr <= ub_rd_addr + ADDR_WIDTH'(1);
               cnt        <= cnt - CNT_WIDTH'(1);
               if (cnt == CNT_WIDTH'(1)) rd_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ub_access_ctrl.sv
// Bench for ub_access_ctrl: cycle-level model of the arbitration and stream timing plus directed literal checks.
module tb_ub_access_ctrl;

   localparam int AW = 7;
   localparam int DW = 56;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          host_wr_req, acc_wr_req;
   logic [5:0]    host_wr_addr, acc_wr_addr;
   logic [DW-1:0] host_wr_data, acc_wr_data;
   logic          host_wr_gnt, acc_wr_gnt;
   logic          ub_wr_en;
   logic [5:0]    ub_wr_addr;
   logic [DW-1:0] ub_wr_data;
   logic          rd_start;
   logic [5:0]    rd_base;
   logic [6:0]    rd_len;
   logic          rd_busy;
   logic [5:0]    ub_rd_addr;
   logic [AW-1:0] ub_rd_data;
   logic          rd_valid;
   logic [AW-1:0] rd_data;
   logic          rd_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ub_access_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .host_wr_req  (host_wr_req),
      .host_wr_addr (host_wr_addr),
      .host_wr_data (host_wr_data),
      .host_wr_gnt  (host_wr_gnt),
      .acc_wr_req   (acc_wr_req),
      .acc_wr_addr  (acc_wr_addr),
      .acc_wr_data  (acc_wr_data),
      .acc_wr_gnt   (acc_wr_gnt),
      .ub_wr_en     (ub_wr_en),
      .ub_wr_addr   (ub_wr_addr),
      .ub_wr_data   (ub_wr_data),
      .rd_start     (rd_start),
      .rd_base      (rd_base),
      .rd_len       (rd_len),
      .rd_busy      (rd_busy),
      .ub_rd_addr   (ub_rd_addr),
      .ub_rd_data   (ub_rd_data),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_done      (rd_done)
   );

   function automatic logic [AW-1:0] pat(input int i);
      return AW'((i * 5 + 3) & 127);
   endfunction

   // Unified buffer as seen by the DUT: edge-timed row write, combinational read.
   logic [AW-1:0] ub_mem [64];
   logic          env_init = 1'b0;
   always @(posedge clk) begin
      if (!env_init) begin
         for (int i = 0; i < 64; i++) ub_mem[i] <= pat(i);
         env_init <= 1'b1;
      end else if (ub_wr_en) begin
         for (int k = 0; k < 8; k++) ub_mem[6'(int'(ub_wr_addr) + k)] <= ub_wr_data[k*AW +: AW];
      end
   end
   assign ub_rd_data = ub_mem[ub_rd_addr];

   // ---------------- reference model state ----------------
   logic [AW-1:0] mem_m [64];
   int            cyc = 0;
   bit            s_valid;
   int            s_t, s_len, s_base;
   bit            last_host;
   bit            wr_pend;
   int            wp_addr;
   logic [DW-1:0] wp_data;
   logic [AW-1:0] cap;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int  rel;
      bit  busy, valid_e, done_e, blocked, gh, ga;
      int  addr_e;
      if (!rst_n) begin
         s_valid   = 1'b0;
         wr_pend   = 1'b0;
         last_host = 1'b1;
         cyc++;
         return;
      end
      rel     = cyc - s_t;
      busy    = s_valid && s_len > 0 && rel >= 1 && rel <= s_len;
      addr_e  = (s_base + rel - 1) % 64;
      valid_e = s_valid && s_len > 0 && rel >= 2 && rel <= s_len + 1;
      done_e  = s_valid && rel == s_len + 1;
`ifdef UB_RD_WR_INTERLOCK_EN
      blocked = busy;
`else
      blocked = 1'b0;
`endif
      gh = 1'b0;
      ga = 1'b0;
      if (!blocked) begin
         if (host_wr_req && acc_wr_req) begin
            ga = last_host;
            gh = !last_host;
         end else begin
            gh = host_wr_req;
            ga = acc_wr_req;
         end
      end
      chk("m_host_gnt", 64'(host_wr_gnt), 64'(gh));
      chk("m_acc_gnt", 64'(acc_wr_gnt), 64'(ga));
      chk("m_ub_wr_en", 64'(ub_wr_en), 64'(wr_pend));
      if (wr_pend) begin
         chk("m_ub_wr_addr", 64'(ub_wr_addr), 64'(wp_addr));
         chk("m_ub_wr_data", 64'(ub_wr_data), 64'(wp_data));
      end
      chk("m_rd_busy", 64'(rd_busy), 64'(busy));
      if (busy) chk("m_ub_rd_addr", 64'(ub_rd_addr), 64'(addr_e));
      chk("m_rd_valid", 64'(rd_valid), 64'(valid_e));
      if (valid_e) chk("m_rd_data", 64'(rd_data), 64'(cap));
      chk("m_rd_done", 64'(rd_done), 64'(done_e));
      // advance to the next cycle: the read of this cycle sees memory before this cycle's write lands
      if (busy) cap = mem_m[addr_e];
      if (wr_pend)
         for (int k = 0; k < 8; k++) mem_m[(wp_addr + k) % 64] = wp_data[k*AW +: AW];
      wr_pend = gh || ga;
      if (gh) begin
         wp_addr   = (int'(host_wr_addr) / 8) * 8;
         wp_data   = host_wr_data;
         last_host = 1'b1;
      end else if (ga) begin
         wp_addr   = (int'(acc_wr_addr) / 8) * 8;
         wp_data   = acc_wr_data;
         last_host = 1'b0;
      end
      if (rd_start && !busy) begin
         s_valid = 1'b1;
         s_t     = cyc;
         s_len   = int'(rd_len);
         s_base  = int'(rd_base);
      end
      cyc++;
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_row(input bit use_acc, input logic [5:0] a, input logic [DW-1:0] d, output int waits);
      logic g;
      if (use_acc) begin
         acc_wr_req = 1'b1; acc_wr_addr = a; acc_wr_data = d;
      end else begin
         host_wr_req = 1'b1; host_wr_addr = a; host_wr_data = d;
      end
      waits = 0;
      #1;
      g = use_acc ? acc_wr_gnt : host_wr_gnt;
      while (!g && waits < 60) begin
         tick();
         waits++;
         #1;
         g = use_acc ? acc_wr_gnt : host_wr_gnt;
      end
      chk("wr_grant_timeout", 64'(g), 64'd1);
      tick();
      host_wr_req = 1'b0;
      acc_wr_req  = 1'b0;
   endtask

   task automatic stream(input logic [5:0] base, input logic [6:0] len, input int ncyc,
                         output int nvalid, output int done_at, output int ndone,
                         output logic [63:0] seen, output int first_v);
      rd_start = 1'b1; rd_base = base; rd_len = len;
      nvalid = 0; done_at = -1; ndone = 0; seen = '0; first_v = -1;
      for (int i = 1; i <= ncyc; i++) begin
         tick();
         if (i == 1) rd_start = 1'b0;
         if (rd_busy) seen[ub_rd_addr] = 1'b1;
         if (rd_valid) begin
            nvalid++;
            if (first_v < 0) first_v = i;
         end
         if (rd_done) begin
            ndone++;
            done_at = i;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int            w, nv, da, nd, fv;
      logic [63:0]   seen;
      logic [DW-1:0] d;
      logic [1:0]    arb_exp [4];
      int            exp_wait;

      arb_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
      for (int i = 0; i < 64; i++) mem_m[i] = pat(i);
      host_wr_req = 0; acc_wr_req = 0; host_wr_addr = 0; acc_wr_addr = 0;
      host_wr_data = '0; acc_wr_data = '0; rd_start = 0; rd_base = 0; rd_len = 0;
      s_valid = 0; s_t = 0; s_len = 0; s_base = 0; last_host = 1; wr_pend = 0;
      wp_addr = 0; wp_data = '0; cap = '0;

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_ub_wr_en", 64'(ub_wr_en), 64'd0);
      chk("rst_ub_wr_addr", 64'(ub_wr_addr), 64'd0);
      chk("rst_ub_wr_data", 64'(ub_wr_data), 64'd0);
      chk("rst_rd_busy", 64'(rd_busy), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd_done", 64'(rd_done), 64'd0);
      chk("rst_ub_rd_addr", 64'(ub_rd_addr), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // both requesters for four cycles: acc first after reset, then alternate
      host_wr_req = 1; host_wr_addr = 6'd24; host_wr_data = {8{7'h11}};
      acc_wr_req  = 1; acc_wr_addr  = 6'd32; acc_wr_data  = {8{7'h22}};
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("arb_seq%0d", i), 64'({acc_wr_gnt, host_wr_gnt}), 64'(arb_exp[i]));
         tick();
      end
      host_wr_req = 0; acc_wr_req = 0;
      tick();

      d = {7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1};
      write_row(1'b0, 6'd8, d, w);
      chk("host_only_wait", 64'(w), 64'd0);
      chk("host_only_en", 64'(ub_wr_en), 64'd1);
      chk("host_only_addr", 64'(ub_wr_addr), 64'd8);
      chk("host_only_data", 64'(ub_wr_data), 64'(56'h10_3050_8183_0201 & 56'h0) | 64'(d));
      tick();

      write_row(1'b0, 6'd13, {8{7'h5A}}, w);
      chk("misaligned_addr", 64'(ub_wr_addr), 64'd8);
      write_row(1'b1, 6'd47, {8{7'h33}}, w);
      chk("acc_misaligned_addr", 64'(ub_wr_addr), 64'd40);
      tick();

      stream(6'd60, 7'd8, 12, nv, da, nd, seen, fv);
      chk("s8_beats", 64'(nv), 64'd8);
      chk("s8_first_valid", 64'(fv), 64'd2);
      chk("s8_done_at", 64'(da), 64'd9);
      chk("s8_done_count", 64'(nd), 64'd1);
      chk("s8_addrs", seen, 64'hF00000000000000F);

      stream(6'd20, 7'd0, 4, nv, da, nd, seen, fv);
      chk("s0_beats", 64'(nv), 64'd0);
      chk("s0_done_at", 64'(da), 64'd1);
      chk("s0_done_count", 64'(nd), 64'd1);

      stream(6'd5, 7'd64, 68, nv, da, nd, seen, fv);
      chk("s64_beats", 64'(nv), 64'd64);
      chk("s64_done_at", 64'(da), 64'd65);
      chk("s64_addrs", seen, 64'hFFFFFFFFFFFFFFFF);

      // second start issued in the cycle the first stream reports done
      stream(6'd40, 7'd3, 4, nv, da, nd, seen, fv);
      chk("b2b_first_done_at", 64'(da), 64'd4);
      stream(6'd50, 7'd2, 5, nv, da, nd, seen, fv);
      chk("b2b_second_done_at", 64'(da), 64'd3);
      chk("b2b_second_beats", 64'(nv), 64'd2);

      // host write into a row the stream is reading
      rd_start = 1; rd_base = 6'd14; rd_len = 7'd10;
      tick();
      rd_start = 0;
      tick();
      tick();
      write_row(1'b0, 6'd16, {7'd77, 7'd66, 7'd55, 7'd44, 7'd33, 7'd22, 7'd11, 7'd99}, w);
`ifdef UB_RD_WR_INTERLOCK_EN
      exp_wait = 8;
`else
      exp_wait = 0;
`endif
      chk("interlock_wait", 64'(w), 64'(exp_wait));
      for (int i = 0; i < 12; i++) tick();

      // reset in the middle of a stream
      rd_start = 1; rd_base = 6'd30; rd_len = 7'd20;
      tick();
      rd_start = 0;
      for (int i = 0; i < 4; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(rd_busy), 64'd0);
      chk("midrst_valid", 64'(rd_valid), 64'd0);
      chk("midrst_done", 64'(rd_done), 64'd0);
      chk("midrst_rd_addr", 64'(ub_rd_addr), 64'd0);
      chk("midrst_rd_data", 64'(rd_data), 64'd0);
      chk("midrst_wr_en", 64'(ub_wr_en), 64'd0);
      chk("midrst_wr_addr", 64'(ub_wr_addr), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (rd_done) nd++;
      end
      chk("midrst_no_done", 64'(nd), 64'd0);

      host_wr_req = 1; acc_wr_req = 1;
      #1;
      chk("rst_ptr_acc", 64'({acc_wr_gnt, host_wr_gnt}), 64'(2'b10));
      tick();
      host_wr_req = 0; acc_wr_req = 0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
